alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- In-order-age, out-of-order-issue reservation station directly upstream of the ALU register-read/execute stage.
- Holds renamed ALU uops until both physical sources are ready, then issues the oldest ready one per cycle.
- Ready bits are set by wakeup broadcasts from the two ALU writeback/bypass paths (alu0, alu1) and by the PRF ready table at dispatch.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
PADDR_W, 6, physical register address width
PAYLOAD_W, 128, opaque uop payload width (uop code, aluType, imm, branchAddr, ROB id, branchType); passed through untouched

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  pipeline flush (mispredict/exception); clears all entries
enq_valid  in  1  dispatch presents a uop
enq_ready  out  1  queue can accept (count < DEPTH)
enq_payload  in  PAYLOAD_W  uop payload
enq_src0_paddr  in  PADDR_W  source 0 physical register
enq_src0_re  in  1  source 0 is read (0 = treat as ready)
enq_src0_rdy  in  1  source 0 already ready per PRF ready table
enq_src1_paddr  in  PADDR_W  source 1 physical register
enq_src1_re  in  1  source 1 is read (0 = immediate, ready)
enq_src1_rdy  in  1  source 1 already ready
enq_dst_paddr  in  PADDR_W  destination physical register
enq_dst_we  in  1  destination written
wk0_valid  in  1  alu0 writeback/bypass wakeup
wk0_paddr  in  PADDR_W  woken register
wk1_valid  in  1  alu1 writeback/bypass wakeup
wk1_paddr  in  PADDR_W  woken register
issue_valid  out  1  selected entry presented
issue_ready  in  1  downstream accepts
issue_payload  out  PAYLOAD_W  selected payload
issue_src0_paddr  out  PADDR_W  selected src0
issue_src1_paddr  out  PADDR_W  selected src1
issue_dst_paddr  out  PADDR_W  selected dst
issue_dst_we  out  1  selected dst write enable
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: compacting queue. Entry 0 is the oldest. Valid entries are contiguous from index 0. Per entry: valid, payload, src0/1 paddr, rdy0, rdy1, dst paddr, dst_we.
- Reset (async, rst=1): all valid=0, count=0. Hence issue_valid=0 and enq_ready=1; other outputs are don't-care but driven to 0.
- Select (combinational): lowest index i with valid & rdy0 & rdy1. issue_valid=1 iff such i exists; issue_* show entry i. Issue latency: an entry woken at edge N can be selected in cycle N+1. There is no same-cycle wakeup-to-select path.
- Issue fires when issue_valid & issue_ready. The selected entry is removed at the clock edge, and entries above it shift down by one, preserving order. If issue_ready=0, state holds and the selection may change next cycle only through new wakeups of an older entry.
- Enqueue fires when enq_valid & enq_ready.
  - The new entry is written at index count, or count-1 if an issue fires in the same cycle.
  - Initial rdyN = ~enq_srcN_re | enq_srcN_rdy | (wk0_valid & wk0_paddr==enq_srcN_paddr) | (wk1_valid & wk1_paddr==enq_srcN_paddr). This same-cycle wakeup capture is mandatory.
- Wakeup: each cycle, for every valid entry, rdyN is set if a valid wk port matches srcN_paddr. It applies to entries that shift in the same cycle, in their new position. rdy bits never clear except when the entry is removed.
- enq_ready = (count < DEPTH). It does not use issue to free a slot in the same cycle, which avoids a ready→valid combinational path. When full, enq_valid is ignored.
- count' = count + enq_fire − issue_fire. Simultaneous enq+issue leaves count unchanged.
- Flush (synchronous, highest priority after rst): at the edge, all valid=0 and count=0. A same-cycle enq and issue are both discarded. issue_valid still reflects pre-flush state in that cycle; the downstream stage gates with flush.
- Both wakeup ports matching the same paddr behaves the same as a single match.

Decomposition:
- Shared package holds: PAddr typedef (PADDR_W), the IQ entry struct (valid, payload, srcs, rdys, dst), and DEPTH default constant.
- One sub-module, iq_wakeup_match: compares one source paddr against both wakeup ports and returns a hit. It is instantiated 2×(DEPTH+1) times (entries plus the enqueue path).

Test Plan:
1. After reset, enqueue A (src0 re=1 rdy=1, src1 re=0) with issue_ready=1 → issue_valid=0 in the enqueue cycle, issue_valid=1 with A next cycle, count 1→0 after the issue edge.
2. Enqueue B (src0=p5 not ready), then C (all ready) → C issues first. Drive wk0_valid=1, wk0_paddr=5 → B issues the following cycle.
3. Enqueue D (src1=p9 not ready) in the same cycle as wk1_valid=1, wk1_paddr=9 → D enters with rdy1=1 and issues next cycle.
4. Fill 8 entries with none ready → count=8, enq_ready=0, further enq_valid ignored. Wake entry 3 → it issues, count=7, and entries 4..7 shift to 3..6 with order preserved.
5. 4 ready entries, issue_ready=0 for 3 cycles → issue_payload stable on entry 0 and count stable. Then raise issue_ready → one issue per cycle, in order.
6. With 5 entries, assert flush together with enq_valid and issue_ready → next cycle count=0, issue_valid=0. Asserting rst mid-operation gives immediate count=0.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// Shared types and defaults for the ALU issue queue.
// Contents:
//   IQ_DEPTH, IQ_PADDR_W, IQ_PAYLOAD_W : default sizing
//   paddr_t                            : physical register address
//   iq_entry_t                         : one reservation-station slot
package alu_issue_queue_pkg;

    localparam int IQ_DEPTH     = 8;
    localparam int IQ_PADDR_W   = 6;
    localparam int IQ_PAYLOAD_W = 128;

    typedef logic [IQ_PADDR_W-1:0] paddr_t;

    typedef struct packed {
        logic                    valid;
        logic [IQ_PAYLOAD_W-1:0] payload;
        paddr_t                  src0;
        paddr_t                  src1;
        logic                    rdy0;
        logic                    rdy1;
        paddr_t                  dst;
        logic                    dst_we;
    } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_wakeup_match.sv
// Compares one source physical register against both ALU wakeup ports.
// Ports:
//   src_paddr            : source register to test
//   wk0_valid, wk0_paddr : alu0 wakeup broadcast
//   wk1_valid, wk1_paddr : alu1 wakeup broadcast
//   hit                  : either valid port names src_paddr
module iq_wakeup_match
    import alu_issue_queue_pkg::*;
#(
    parameter int PADDR_W = IQ_PADDR_W
) (
    input  logic [PADDR_W-1:0] src_paddr,
    input  logic               wk0_valid,
    input  logic [PADDR_W-1:0] wk0_paddr,
    input  logic               wk1_valid,
    input  logic [PADDR_W-1:0] wk1_paddr,
    output logic               hit
);

    assign hit = (wk0_valid && (wk0_paddr == src_paddr)) ||
                 (wk1_valid && (wk1_paddr == src_paddr));

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting, age-ordered ALU reservation station. Entry 0 is the oldest;
// valid entries are contiguous from index 0. The oldest entry whose two
// sources are ready is presented for issue each cycle.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   flush                  : synchronous clear of all entries
//   enq_*                  : dispatch interface (valid/ready + uop fields)
//   wk0_*, wk1_*           : ALU writeback/bypass wakeup broadcasts
//   issue_*                : selected uop toward register-read (valid/ready)
//   count                  : occupied entries
// PADDR_W / PAYLOAD_W must match the package entry layout.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int PADDR_W   = IQ_PADDR_W,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [PAYLOAD_W-1:0]       enq_payload,
    input  logic [PADDR_W-1:0]         enq_src0_paddr,
    input  logic                       enq_src0_re,
    input  logic                       enq_src0_rdy,
    input  logic [PADDR_W-1:0]         enq_src1_paddr,
    input  logic                       enq_src1_re,
    input  logic                       enq_src1_rdy,
    input  logic [PADDR_W-1:0]         enq_dst_paddr,
    input  logic                       enq_dst_we,
    input  logic                       wk0_valid,
    input  logic [PADDR_W-1:0]         wk0_paddr,
    input  logic                       wk1_valid,
    input  logic [PADDR_W-1:0]         wk1_paddr,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [PAYLOAD_W-1:0]       issue_payload,
    output logic [PADDR_W-1:0]         issue_src0_paddr,
    output logic [PADDR_W-1:0]         issue_src1_paddr,
    output logic [PADDR_W-1:0]         issue_dst_paddr,
    output logic                       issue_dst_we,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t             ent      [DEPTH];
    iq_entry_t             woken    [DEPTH+1];
    iq_entry_t             ent_nxt  [DEPTH];
    iq_entry_t             enq_ent;
    logic      [DEPTH-1:0] hit0;
    logic      [DEPTH-1:0] hit1;
    logic                  enq_hit0;
    logic                  enq_hit1;
    logic                  sel_found;
    logic      [IDX_W-1:0] sel_idx;
    logic                  enq_fire;
    logic                  issue_fire;
    logic      [CNT_W-1:0] enq_pos;

    // Wakeup compare per stored source, plus the two dispatch sources so a
    // broadcast in the dispatch cycle is not lost.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        iq_wakeup_match #(.PADDR_W(PADDR_W)) u_m0 (
            .src_paddr (ent[i].src0),
            .wk0_valid (wk0_valid),
            .wk0_paddr (wk0_paddr),
            .wk1_valid (wk1_valid),
            .wk1_paddr (wk1_paddr),
            .hit       (hit0[i])
        );
        iq_wakeup_match #(.PADDR_W(PADDR_W)) u_m1 (
            .src_paddr (ent[i].src1),
            .wk0_valid (wk0_valid),
            .wk0_paddr (wk0_paddr),
            .wk1_valid (wk1_valid),
            .wk1_paddr (wk1_paddr),
            .hit       (hit1[i])
        );
    end

    iq_wakeup_match #(.PADDR_W(PADDR_W)) u_enq_m0 (
        .src_paddr (enq_src0_paddr),
        .wk0_valid (wk0_valid),
        .wk0_paddr (wk0_paddr),
        .wk1_valid (wk1_valid),
        .wk1_paddr (wk1_paddr),
        .hit       (enq_hit0)
    );

    iq_wakeup_match #(.PADDR_W(PADDR_W)) u_enq_m1 (
        .src_paddr (enq_src1_paddr),
        .wk0_valid (wk0_valid),
        .wk0_paddr (wk0_paddr),
        .wk1_valid (wk1_valid),
        .wk1_paddr (wk1_paddr),
        .hit       (enq_hit1)
    );

    // Oldest-ready select; only registered rdy bits participate, so a wakeup
    // becomes visible to select one cycle after it is broadcast.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].valid && ent[i].rdy0 && ent[i].rdy1) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Not relieved by a same-cycle issue, keeping issue_ready off the
    // enq_ready path.
    assign enq_ready  = (count < CNT_W'(DEPTH));
    assign enq_fire   = enq_valid && enq_ready;
    assign issue_fire = sel_found && issue_ready;
    assign enq_pos    = count - CNT_W'(issue_fire);

    always_comb begin
        enq_ent         = '0;
        enq_ent.valid   = 1'b1;
        enq_ent.payload = enq_payload;
        enq_ent.src0    = enq_src0_paddr;
        enq_ent.src1    = enq_src1_paddr;
        enq_ent.rdy0    = !enq_src0_re || enq_src0_rdy || enq_hit0;
        enq_ent.rdy1    = !enq_src1_re || enq_src1_rdy || enq_hit1;
        enq_ent.dst     = enq_dst_paddr;
        enq_ent.dst_we  = enq_dst_we;
    end

    // Wakeup is applied before the shift so that an entry moving down
    // carries this cycle's wakeup into its new slot. woken[DEPTH] is the
    // empty slot shifted into the top.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]      = ent[i];
            woken[i].rdy0 = ent[i].rdy0 || (ent[i].valid && hit0[i]);
            woken[i].rdy1 = ent[i].rdy1 || (ent[i].valid && hit1[i]);
        end
        woken[DEPTH] = '0;
    end

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_nxt[j] = woken[j];
            if (issue_fire && (j >= int'(sel_idx))) begin
                ent_nxt[j] = woken[j+1];
            end
            if (enq_fire && (j == int'(enq_pos))) begin
                ent_nxt[j] = enq_ent;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            count <= count + CNT_W'(enq_fire) - CNT_W'(issue_fire);
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= ent_nxt[i];
            end
        end
    end

    always_comb begin
        issue_valid      = sel_found;
        issue_payload    = '0;
        issue_src0_paddr = '0;
        issue_src1_paddr = '0;
        issue_dst_paddr  = '0;
        issue_dst_we     = 1'b0;
        if (sel_found) begin
            issue_payload    = ent[sel_idx].payload;
            issue_src0_paddr = ent[sel_idx].src0;
            issue_src1_paddr = ent[sel_idx].src1;
            issue_dst_paddr  = ent[sel_idx].dst;
            issue_dst_we     = ent[sel_idx].dst_we;
        end
    end

endmodule
